// File: rtl/mod_counter_pkg.sv
// Shared defaults and width helper for the modulo-N counter family.
package mod_counter_pkg;

  localparam int unsigned DEFAULT_MODULUS = 31;
  localparam int unsigned DEFAULT_WRAP_W  = 8;

  // A 1-bit count is still needed for MODULUS == 2 (and a degenerate MODULUS == 1).
  function automatic int unsigned clog2_safe(input int unsigned n);
    return (n <= 2) ? 1 : int'($clog2(n));
  endfunction

endpackage

// File: rtl/mod_next_value.sv
// Combinational successor/predecessor of a modulo-MODULUS count, with terminal detect.
module mod_next_value
  import mod_counter_pkg::*;
#(
  parameter int unsigned MODULUS = DEFAULT_MODULUS,
  parameter int unsigned WIDTH   = clog2_safe(MODULUS)
) (
  input  logic [WIDTH-1:0] count,
  input  logic             up_dn,
  output logic [WIDTH-1:0] next,
  output logic             at_terminal
);

  localparam logic [WIDTH-1:0] MaxVal = WIDTH'(MODULUS - 1);

  // Wrap is taken explicitly so non-power-of-two moduli never leave 0..MODULUS-1.
  always_comb begin
    at_terminal = up_dn ? (count == MaxVal) : (count == '0);
    if (at_terminal) begin
      next = up_dn ? '0 : MaxVal;
    end else begin
      next = up_dn ? (count + 1'b1) : (count - 1'b1);
    end
  end

endmodule

// File: rtl/mod_n_counter.sv
// Registered, loadable up/down modulo-N counter with cascade terminal count,
// saturating wrap counter and out-of-range load flag.
module mod_n_counter
  import mod_counter_pkg::*;
#(
  parameter int unsigned MODULUS = DEFAULT_MODULUS,
  parameter int unsigned WIDTH   = clog2_safe(MODULUS),
  parameter int unsigned WRAP_W  = DEFAULT_WRAP_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              load,
  input  logic [WIDTH-1:0]  load_val,
  input  logic              en,
  input  logic              up_dn,
  output logic [WIDTH-1:0]  count,
  output logic              tc,
  output logic [WRAP_W-1:0] wrap_cnt,
  output logic              load_err
);

  localparam logic [WIDTH-1:0] MaxVal = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0]  count_q, count_d;
  logic [WIDTH-1:0]  step_val;
  logic              at_terminal;
  logic [WRAP_W-1:0] wrap_q, wrap_d;
  logic              load_err_q, load_err_d;

  mod_next_value #(
    .MODULUS (MODULUS),
    .WIDTH   (WIDTH)
  ) u_next (
    .count       (count_q),
    .up_dn       (up_dn),
    .next        (step_val),
    .at_terminal (at_terminal)
  );

  // Zero-latency so a following stage can use it directly as its enable.
  assign tc = en & at_terminal;

  always_comb begin
    count_d    = count_q;
    wrap_d     = wrap_q;
    load_err_d = 1'b0;
    if (clr) begin
      count_d = '0;
      wrap_d  = '0;
    end else if (load) begin
      if (load_val > MaxVal) begin
        count_d    = MaxVal;
        load_err_d = 1'b1;
      end else begin
        count_d = load_val;
      end
    end else if (en) begin
      count_d = step_val;
      if (at_terminal && (wrap_q != '1)) begin
        wrap_d = wrap_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q    <= '0;
      wrap_q     <= '0;
      load_err_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      wrap_q     <= wrap_d;
      load_err_q <= load_err_d;
    end
  end

  assign count    = count_q;
  assign wrap_cnt = wrap_q;
  assign load_err = load_err_q;

endmodule

// File: tb/tb_mod_n_counter.sv
// Randomized and directed bench for mod_n_counter: four instances (31, cascaded 31,
// 16 with 2-bit wrap counter, 2) checked every cycle against an arithmetic model.
module tb_mod_n_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [3:0] rst_v = '0;
  logic [3:0] clr_v = '0;
  logic [3:0] ld_v  = '0;
  logic [3:0] en_v  = '0;
  logic [3:0] up_v  = '1;
  int         lv [4];

  logic [4:0] cnt_a, cnt_b;
  logic [3:0] cnt_c;
  logic [0:0] cnt_d;
  logic [7:0] wr_a, wr_b, wr_d;
  logic [1:0] wr_c;
  logic       tc_a, tc_b, tc_c, tc_d;
  logic       er_a, er_b, er_c, er_d;

  mod_n_counter #(.MODULUS(31), .WRAP_W(8)) u_a (
    .clk(clk), .rst_n(rst_v[0]), .clr(clr_v[0]), .load(ld_v[0]), .load_val(lv[0][4:0]),
    .en(en_v[0]), .up_dn(up_v[0]), .count(cnt_a), .tc(tc_a), .wrap_cnt(wr_a),
    .load_err(er_a)
  );

  // Second stage of a cascade: enabled by the first stage's terminal count.
  mod_n_counter #(.MODULUS(31), .WRAP_W(8)) u_b (
    .clk(clk), .rst_n(rst_v[1]), .clr(clr_v[1]), .load(ld_v[1]), .load_val(lv[1][4:0]),
    .en(tc_a), .up_dn(up_v[1]), .count(cnt_b), .tc(tc_b), .wrap_cnt(wr_b),
    .load_err(er_b)
  );

  mod_n_counter #(.MODULUS(16), .WRAP_W(2)) u_c (
    .clk(clk), .rst_n(rst_v[2]), .clr(clr_v[2]), .load(ld_v[2]), .load_val(lv[2][3:0]),
    .en(en_v[2]), .up_dn(up_v[2]), .count(cnt_c), .tc(tc_c), .wrap_cnt(wr_c),
    .load_err(er_c)
  );

  mod_n_counter #(.MODULUS(2), .WRAP_W(8)) u_d (
    .clk(clk), .rst_n(rst_v[3]), .clr(clr_v[3]), .load(ld_v[3]), .load_val(lv[3][0:0]),
    .en(en_v[3]), .up_dn(up_v[3]), .count(cnt_d), .tc(tc_d), .wrap_cnt(wr_d),
    .load_err(er_d)
  );

  // ---------------- behavioural model ----------------
  int mc [4];
  int mw [4];
  int me [4];

  function automatic int mod_of(input int i);
    case (i)
      2:       return 16;
      3:       return 2;
      default: return 31;
    endcase
  endfunction

  function automatic int wmax_of(input int i);
    return (i == 2) ? 3 : 255;
  endfunction

  function automatic int lvmax_of(input int i);
    case (i)
      2:       return 15;
      3:       return 1;
      default: return 31;
    endcase
  endfunction

  function automatic bit at_term(input int i);
    return up_v[i] ? (mc[i] == mod_of(i) - 1) : (mc[i] == 0);
  endfunction

  function automatic bit m_tc0();
    return en_v[0] && at_term(0);
  endfunction

  function automatic bit m_en(input int i);
    return (i == 1) ? m_tc0() : bit'(en_v[i]);
  endfunction

  function automatic bit m_tc(input int i);
    return m_en(i) && at_term(i);
  endfunction

  function automatic int nxt_c(input int i);
    int m;
    m = mod_of(i);
    if (!rst_v[i] || clr_v[i]) return 0;
    if (ld_v[i]) return (lv[i] < m) ? lv[i] : m - 1;
    if (m_en(i)) return up_v[i] ? (mc[i] + 1) % m : (mc[i] + m - 1) % m;
    return mc[i];
  endfunction

  function automatic int nxt_w(input int i);
    if (!rst_v[i] || clr_v[i]) return 0;
    if (ld_v[i]) return mw[i];
    if (m_tc(i)) return (mw[i] < wmax_of(i)) ? mw[i] + 1 : mw[i];
    return mw[i];
  endfunction

  function automatic int nxt_e(input int i);
    if (!rst_v[i] || clr_v[i]) return 0;
    return (ld_v[i] && lv[i] >= mod_of(i)) ? 1 : 0;
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      mc[i] <= nxt_c(i);
      mw[i] <= nxt_w(i);
      me[i] <= nxt_e(i);
    end
  end

  // ---------------- checking ----------------
  int n_chk  = 0;
  int n_fail = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic check_inst(input int i, input int c, input int w, input int e, input int t);
    chk($sformatf("inst%0d.count", i), c, mc[i]);
    chk($sformatf("inst%0d.wrap_cnt", i), w, mw[i]);
    chk($sformatf("inst%0d.load_err", i), e, me[i]);
    chk($sformatf("inst%0d.tc", i), t, int'(m_tc(i)));
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      check_inst(0, int'(cnt_a), int'(wr_a), int'(er_a), int'(tc_a));
      check_inst(1, int'(cnt_b), int'(wr_b), int'(er_b), int'(tc_b));
      check_inst(2, int'(cnt_c), int'(wr_c), int'(er_c), int'(tc_c));
      check_inst(3, int'(cnt_d), int'(wr_d), int'(er_d), int'(tc_d));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < 4; i++) lv[i] = 0;
    step();
    chk_on = 1'b1;
    chk("reset.count", int'(cnt_a), 0);
    chk("reset.wrap_cnt", int'(wr_a), 0);
    chk("reset.load_err", int'(er_a), 0);
    chk("reset.tc_idle", int'(tc_a), 0);
    en_v[0] = 1'b1; up_v[0] = 1'b0; #1;
    chk("reset.tc_down_en", int'(tc_a), 1);

    // Up count with the cascade: 961 = 31*31 cycles returns both stages to 0.
    rst_v = '1; up_v = '1; en_v[0] = 1'b1;
    repeat (30) step();
    chk("up.count30", int'(cnt_a), 30);
    chk("up.tc_at30", int'(tc_a), 1);
    chk("casc.b_still0", int'(cnt_b), 0);
    step();
    chk("up.wrap_to0", int'(cnt_a), 0);
    chk("up.wrap_cnt1", int'(wr_a), 1);
    chk("casc.b_advanced", int'(cnt_b), 1);
    repeat (930) step();
    chk("casc.a_final", int'(cnt_a), 0);
    chk("casc.b_final", int'(cnt_b), 0);
    chk("casc.a_wraps", int'(wr_a), 31);
    chk("casc.b_wraps", int'(wr_b), 1);

    // Down count from reset.
    rst_v[1:0] = 2'b00; step(); rst_v[1:0] = 2'b11;
    up_v[0] = 1'b0; #1;
    chk("down.tc_first", int'(tc_a), 1);
    step();
    chk("down.count30", int'(cnt_a), 30);
    chk("down.wrap1", int'(wr_a), 1);
    repeat (30) step();
    chk("down.back0", int'(cnt_a), 0);

    // Load beats enable; out-of-range load clamps and flags for one cycle.
    ld_v[0] = 1'b1; lv[0] = 17; up_v[0] = 1'b1; step();
    chk("load.count17", int'(cnt_a), 17);
    chk("load.wrap_kept", int'(wr_a), 1);
    lv[0] = 31; step();
    chk("load.clamp30", int'(cnt_a), 30);
    chk("load.err_set", int'(er_a), 1);
    ld_v[0] = 1'b0; en_v[0] = 1'b0; step();
    chk("load.err_clear", int'(er_a), 0);
    chk("load.hold30", int'(cnt_a), 30);

    // Reset wins over a simultaneous load.
    ld_v[0] = 1'b1; lv[0] = 5; step();
    rst_v[0] = 1'b0; lv[0] = 9; step();
    chk("rst_over_load", int'(cnt_a), 0);
    rst_v[0] = 1'b1; ld_v[0] = 1'b0;

    // MODULUS=16, WRAP_W=2: saturation then clear.
    rst_v[2] = 1'b0; step(); rst_v[2] = 1'b1;
    en_v[2] = 1'b1; up_v[2] = 1'b1;
    repeat (80) step();
    chk("m16.count0", int'(cnt_c), 0);
    chk("m16.wrap_sat", int'(wr_c), 3);
    clr_v[2] = 1'b1; step(); clr_v[2] = 1'b0;
    chk("m16.clr_count", int'(cnt_c), 0);
    chk("m16.clr_wrap", int'(wr_c), 0);
    up_v[2] = 1'b0; step();
    chk("m16.down_wrap", int'(cnt_c), 15);
    chk("m16.down_wrap_cnt", int'(wr_c), 1);

    // MODULUS=2 up and down.
    rst_v[3] = 1'b0; step(); rst_v[3] = 1'b1;
    en_v[3] = 1'b1; up_v[3] = 1'b1;
    step(); chk("m2.up1", int'(cnt_d), 1);
    step(); chk("m2.up_wrap", int'(cnt_d), 0);
    chk("m2.wrap1", int'(wr_d), 1);
    up_v[3] = 1'b0; #1;
    chk("m2.tc_down", int'(tc_d), 1);
    step(); chk("m2.down_wrap", int'(cnt_d), 1);
    chk("m2.wrap2", int'(wr_d), 2);
    step(); chk("m2.down0", int'(cnt_d), 0);
    chk("m2.wrap_hold", int'(wr_d), 2);

    // Randomized traffic on all four instances.
    repeat (3000) begin
      for (int i = 0; i < 4; i++) begin
        rst_v[i] = ($urandom_range(49) != 0);
        clr_v[i] = ($urandom_range(19) == 0);
        ld_v[i]  = ($urandom_range(7) == 0);
        lv[i]    = int'($urandom_range(lvmax_of(i)));
        en_v[i]  = ($urandom_range(3) != 0);
        up_v[i]  = $urandom_range(1) != 0;
      end
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
